// File: rtl/svc_pix_vga.sv
// svc_pix_vga -- VGA timing generator and pixel-stream sink.
//
// Consumes a valid/ready pixel stream tagged with (x,y) and places each pixel
// on registered VGA outputs. hsync/vsync/visible come from free-running
// counters compared against programmable timing inputs. Each pixel's tag is
// compared against the counter position; on underflow or a tag mismatch the
// block drops to RESYNC, drains the stream up to the next (0,0) pixel and
// relocks at the following frame boundary.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   s_pix_valid/ready           stream handshake (ready is combinational)
//   s_pix_red/grn/blu           stream colour
//   s_pix_x, s_pix_y            stream pixel coordinate tag
//   h_visible..h_line_end       horizontal timing (line_end = total-1)
//   v_visible..v_frame_end      vertical timing (frame_end = total-1)
//   vga_hsync, vga_vsync        active-low syncs (registered)
//   vga_red/grn/blu             colour, zero outside visible area (registered)
//   vga_error                   one-cycle pulse on underflow or tag mismatch
//   locked                      high while in RUN
module svc_pix_vga #(
  parameter int H_WIDTH     = 12,
  parameter int V_WIDTH     = 12,
  parameter int COLOR_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_pix_valid,
  input  logic [COLOR_WIDTH-1:0] s_pix_red,
  input  logic [COLOR_WIDTH-1:0] s_pix_grn,
  input  logic [COLOR_WIDTH-1:0] s_pix_blu,
  input  logic [H_WIDTH-1:0]     s_pix_x,
  input  logic [V_WIDTH-1:0]     s_pix_y,
  output logic                   s_pix_ready,
  input  logic [H_WIDTH-1:0]     h_visible,
  input  logic [H_WIDTH-1:0]     h_sync_start,
  input  logic [H_WIDTH-1:0]     h_sync_end,
  input  logic [H_WIDTH-1:0]     h_line_end,
  input  logic [V_WIDTH-1:0]     v_visible,
  input  logic [V_WIDTH-1:0]     v_sync_start,
  input  logic [V_WIDTH-1:0]     v_sync_end,
  input  logic [V_WIDTH-1:0]     v_frame_end,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic [COLOR_WIDTH-1:0] vga_red,
  output logic [COLOR_WIDTH-1:0] vga_grn,
  output logic [COLOR_WIDTH-1:0] vga_blu,
  output logic                   vga_error,
  output logic                   locked
);

  localparam logic [0:0] ST_RESYNC = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;

  logic [H_WIDTH-1:0]     h_cnt_q, h_cnt_d;
  logic [V_WIDTH-1:0]     v_cnt_q, v_cnt_d;
  logic [0:0]             state_q, state_d;
  logic                   hsync_q, hsync_d, vsync_q, vsync_d;
  logic [COLOR_WIDTH-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic                   err_q, err_d, locked_q;
  logic                   ready_c;

  logic h_wrap, vis, frame_last, head_origin, tag_match;

  assign h_wrap      = (h_cnt_q == h_line_end);
  assign vis         = (h_cnt_q < h_visible) && (v_cnt_q < v_visible);
  assign frame_last  = h_wrap && (v_cnt_q == v_frame_end);
  assign head_origin = s_pix_valid && (s_pix_x == '0) && (s_pix_y == '0);
  assign tag_match   = (s_pix_x == h_cnt_q) && (s_pix_y == v_cnt_q);

  always_comb begin
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) v_cnt_d = (v_cnt_q == v_frame_end) ? '0 : v_cnt_q + 1'b1;
  end

  assign hsync_d = !((h_cnt_q >= h_sync_start) && (h_cnt_q < h_sync_end));
  assign vsync_d = !((v_cnt_q >= v_sync_start) && (v_cnt_q < v_sync_end));

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    red_d   = '0;
    grn_d   = '0;
    blu_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      ST_RESYNC: begin
        // Drain everything except a (0,0) head, which is held for relock.
        ready_c = !head_origin;
        if (frame_last && head_origin) state_d = ST_RUN;
      end
      ST_RUN: begin
        ready_c = vis;
        if (vis) begin
          if (s_pix_valid && tag_match) begin
            red_d = s_pix_red;
            grn_d = s_pix_grn;
            blu_d = s_pix_blu;
          end else begin
            // Underflow or out-of-phase pixel (a mismatched one is consumed).
            err_d   = 1'b1;
            state_d = ST_RESYNC;
          end
        end
      end
      default: state_d = ST_RESYNC;
    endcase
  end

  assign s_pix_ready = ready_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      state_q  <= ST_RESYNC;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      red_q    <= '0;
      grn_q    <= '0;
      blu_q    <= '0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      state_q  <= state_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      red_q    <= red_d;
      grn_q    <= grn_d;
      blu_q    <= blu_d;
      err_q    <= err_d;
      // Registered from next state so locked tracks the RUN state cycle-exact.
      locked_q <= (state_d == ST_RUN);
    end
  end

  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;
  assign vga_red   = red_q;
  assign vga_grn   = grn_q;
  assign vga_blu   = blu_q;
  assign vga_error = err_q;
  assign locked    = locked_q;

endmodule
